// File: rtl/ras_checkpointed_pkg.sv
// Branch-prediction package slice: RAS geometry defaults, checkpoint record and op decode.
// Macro RAS_REPAIR_WRITE_EN adds the top-entry value to the checkpoint record.
package ras_checkpointed_pkg;

  localparam int unsigned RAS_DEPTH        = 8;
  localparam int unsigned RAS_TARGET_WIDTH = 12;
  localparam int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_COUNT_WIDTH  = LOG_RAS_DEPTH + 1;

  typedef enum logic [2:0] {
    RAS_OP_HOLD,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_SWAP,
    RAS_OP_RESTORE
  } ras_op_e;

  // Stored by the backend per in-flight branch.
  typedef struct packed {
    logic [LOG_RAS_DEPTH-1:0]    index;
    logic [RAS_COUNT_WIDTH-1:0]  count;
`ifdef RAS_REPAIR_WRITE_EN
    logic [RAS_TARGET_WIDTH-1:0] target;
`endif
  } ras_checkpoint_t;

  // Restore outranks everything; push+pop together is a top-entry replace.
  function automatic ras_op_e ras_decode_op(input logic push, input logic pop,
                                            input logic restore);
    if (restore)      return RAS_OP_RESTORE;
    if (push && pop)  return RAS_OP_SWAP;
    if (push)         return RAS_OP_PUSH;
    if (pop)          return RAS_OP_POP;
    return RAS_OP_HOLD;
  endfunction

endpackage

// File: rtl/ras_checkpointed_if.sv
// Request/response bundle between the prediction front end (master) and the RAS (slave).
interface ras_checkpointed_if #(
  parameter int unsigned RAS_DEPTH        = ras_checkpointed_pkg::RAS_DEPTH,
  parameter int unsigned RAS_TARGET_WIDTH = ras_checkpointed_pkg::RAS_TARGET_WIDTH
);

  localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic                        push_valid;
  logic [RAS_TARGET_WIDTH-1:0] push_target;
  logic                        pop_valid;
  logic                        restore_valid;
  logic [IDX_W-1:0]            restore_index;
  logic [CNT_W-1:0]            restore_count;
  logic [RAS_TARGET_WIDTH-1:0] restore_target;
  logic [RAS_TARGET_WIDTH-1:0] top_target;
  logic                        empty;
  logic [IDX_W-1:0]            index;
  logic [CNT_W-1:0]            count;

  modport master (
    output push_valid, push_target, pop_valid,
    output restore_valid, restore_index, restore_count, restore_target,
    input  top_target, empty, index, count
  );

  modport slave (
    input  push_valid, push_target, pop_valid,
    input  restore_valid, restore_index, restore_count, restore_target,
    output top_target, empty, index, count
  );

endinterface

// File: rtl/ras_checkpointed.sv
// Return address stack with overflow wrap-around and single-cycle checkpoint restore.
// Macro RAS_REPAIR_WRITE_EN: restore also rewrites the entry at the restored pointer.
module ras_checkpointed #(
  parameter int unsigned RAS_DEPTH        = ras_checkpointed_pkg::RAS_DEPTH,
  parameter int unsigned RAS_TARGET_WIDTH = ras_checkpointed_pkg::RAS_TARGET_WIDTH
) (
  input logic               CLK,
  input logic               nRST,
  ras_checkpointed_if.slave ras
);

  localparam int unsigned      IDX_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [RAS_TARGET_WIDTH-1:0] entry_q [RAS_DEPTH];
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        wr_en;
  logic [IDX_W-1:0]            wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;
  ras_checkpointed_pkg::ras_op_e op;

  assign op = ras_checkpointed_pkg::ras_decode_op(ras.push_valid, ras.pop_valid,
                                                  ras.restore_valid);

`ifndef RAS_REPAIR_WRITE_EN
  logic unused_restore_target;
  assign unused_restore_target = ^ras.restore_target;
`endif

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = ras.push_target;
    unique case (op)
      ras_checkpointed_pkg::RAS_OP_RESTORE: begin
        ptr_d = ras.restore_index;
        cnt_d = (ras.restore_count > CNT_FULL) ? CNT_FULL : ras.restore_count;
`ifdef RAS_REPAIR_WRITE_EN
        wr_en   = 1'b1;
        wr_idx  = ras.restore_index;
        wr_data = ras.restore_target;
`endif
      end
      ras_checkpointed_pkg::RAS_OP_PUSH: begin
        // Pointer wraps modulo depth; a full stack silently drops its oldest entry.
        ptr_d  = ptr_q + IDX_ONE;
        wr_en  = 1'b1;
        wr_idx = ptr_q + IDX_ONE;
        cnt_d  = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_ONE;
      end
      ras_checkpointed_pkg::RAS_OP_POP: begin
        if (cnt_q != '0) begin
          ptr_d = ptr_q - IDX_ONE;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ras_checkpointed_pkg::RAS_OP_SWAP: begin
        wr_en = 1'b1;
        if (cnt_q == '0) cnt_d = CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) entry_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) entry_q[wr_idx] <= wr_data;
    end
  end

  assign ras.top_target = entry_q[ptr_q];
  assign ras.empty      = (cnt_q == '0);
  assign ras.index      = ptr_q;
  assign ras.count      = cnt_q;

endmodule

// File: tb/tb_ras_checkpointed.sv
// Self-checking bench for ras_checkpointed: directed scenarios plus randomized traffic
// against a wrap-around stack model.
module tb_ras_checkpointed;
  import ras_checkpointed_pkg::*;

  localparam int unsigned D  = RAS_DEPTH;
  localparam int unsigned TW = RAS_TARGET_WIDTH;
  localparam int unsigned IW = LOG_RAS_DEPTH;
  localparam int unsigned CW = RAS_COUNT_WIDTH;
  localparam int unsigned SW = TW + 1 + IW + CW;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  ras_checkpointed_if #(.RAS_DEPTH(D), .RAS_TARGET_WIDTH(TW)) bus ();

  ras_checkpointed #(.RAS_DEPTH(D), .RAS_TARGET_WIDTH(TW)) dut (
    .CLK (clk),
    .nRST(nrst),
    .ras (bus)
  );

  always #5 clk = ~clk;

  // Reference model: circular buffer of D slots, top slot number, live entry count.
  logic [TW-1:0] m_arr [D];
  int            m_ptr;
  int            m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < int'(D); i++) m_arr[i] = '0;
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit pv, input logic [TW-1:0] pt, input bit pp,
                                     input bit rv, input int ri, input int rc,
                                     input logic [TW-1:0] rt);
    if (rv) begin
      m_ptr = ri;
      m_cnt = (rc > int'(D)) ? int'(D) : rc;
`ifdef RAS_REPAIR_WRITE_EN
      m_arr[ri] = rt;
`endif
    end else if (pv && pp) begin
      m_arr[m_ptr] = pt;
      if (m_cnt == 0) m_cnt = 1;
    end else if (pv) begin
      m_ptr = (m_ptr + 1) % int'(D);
      m_arr[m_ptr] = pt;
      if (m_cnt < int'(D)) m_cnt = m_cnt + 1;
    end else if (pp && m_cnt > 0) begin
      m_ptr = (m_ptr + int'(D) - 1) % int'(D);
      m_cnt = m_cnt - 1;
    end
  endfunction

  function automatic logic [SW-1:0] dut_state();
    return {bus.top_target, bus.empty, bus.index, bus.count};
  endfunction

  function automatic logic [SW-1:0] exp_state(input int t, input bit e, input int i, input int c);
    return {TW'(t), e, IW'(i), CW'(c)};
  endfunction

  function automatic logic [SW-1:0] model_state();
    return {m_arr[m_ptr], (m_cnt == 0), IW'(m_ptr), CW'(m_cnt)};
  endfunction

  // Inputs change on the falling edge; the model advances with the rising edge.
  task automatic drive(input bit pv, input logic [TW-1:0] pt, input bit pp, input bit rv,
                       input int ri, input int rc, input logic [TW-1:0] rt);
    bus.push_valid     = pv;
    bus.push_target    = pt;
    bus.pop_valid      = pp;
    bus.restore_valid  = rv;
    bus.restore_index  = IW'(ri);
    bus.restore_count  = CW'(rc);
    bus.restore_target = rt;
    @(posedge clk);
    model_step(pv, pt, pp, rv, ri, rc, rt);
    @(negedge clk);
    bus.push_valid    = 1'b0;
    bus.pop_valid     = 1'b0;
    bus.restore_valid = 1'b0;
  endtask

  task automatic do_push(input logic [TW-1:0] t);
    drive(1'b1, t, 1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic do_pop();
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_state() !== exp_state(0, 1'b1, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_held: got %h expected %h", dut_state(), exp_state(0, 1'b1, 0, 0));
    end
    nrst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_state() !== exp_state(0, 1'b1, 0, 0)) begin
      n_errors++;
      $display("FAIL reset_released: got %h expected %h", dut_state(), exp_state(0, 1'b1, 0, 0));
    end
  endtask

  task automatic test_push_pop();
    logic [SW-1:0] want [3];
    apply_reset();
    do_push(12'h111);
    do_push(12'h222);
    do_push(12'h333);
    n_checks++;
    if (dut_state() !== exp_state('h333, 1'b0, 3, 3)) begin
      n_errors++;
      $display("FAIL pushpop_after_push: got %h expected %h", dut_state(), exp_state('h333, 1'b0, 3, 3));
    end
    want[0] = exp_state('h222, 1'b0, 2, 2);
    want[1] = exp_state('h111, 1'b0, 1, 1);
    want[2] = exp_state('h000, 1'b1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      do_pop();
      n_checks++;
      if (dut_state() !== want[k]) begin
        n_errors++;
        $display("FAIL pushpop_pop%0d: got %h expected %h", k, dut_state(), want[k]);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int v = 1; v <= 9; v++) do_push(TW'(v));
    n_checks++;
    if (dut_state() !== exp_state('h009, 1'b0, 1, 8)) begin
      n_errors++;
      $display("FAIL overflow_full: got %h expected %h", dut_state(), exp_state('h009, 1'b0, 1, 8));
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.top_target !== TW'(9 - k)) begin
        n_errors++;
        $display("FAIL overflow_pop%0d_top: got %h expected %h", k, bus.top_target, TW'(9 - k));
      end
      do_pop();
    end
    n_checks++;
    if (dut_state() !== exp_state('h009, 1'b1, 1, 0)) begin
      n_errors++;
      $display("FAIL overflow_drained: got %h expected %h", dut_state(), exp_state('h009, 1'b1, 1, 0));
    end
    do_pop();
    n_checks++;
    if (dut_state() !== exp_state('h009, 1'b1, 1, 0)) begin
      n_errors++;
      $display("FAIL overflow_pop_empty: got %h expected %h", dut_state(), exp_state('h009, 1'b1, 1, 0));
    end
  endtask

  task automatic test_push_and_pop();
    apply_reset();
    drive(1'b1, 12'h077, 1'b1, 1'b0, 0, 0, '0);
    n_checks++;
    if (dut_state() !== exp_state('h077, 1'b0, 0, 1)) begin
      n_errors++;
      $display("FAIL swap_on_empty: got %h expected %h", dut_state(), exp_state('h077, 1'b0, 0, 1));
    end
    apply_reset();
    do_push(12'h055);
    do_push(12'h0AA);
    drive(1'b1, 12'h0BB, 1'b1, 1'b0, 0, 0, '0);
    n_checks++;
    if (dut_state() !== exp_state('h0BB, 1'b0, 2, 2)) begin
      n_errors++;
      $display("FAIL swap_top: got %h expected %h", dut_state(), exp_state('h0BB, 1'b0, 2, 2));
    end
    do_pop();
    n_checks++;
    if (dut_state() !== exp_state('h055, 1'b0, 1, 1)) begin
      n_errors++;
      $display("FAIL swap_below: got %h expected %h", dut_state(), exp_state('h055, 1'b0, 1, 1));
    end
  endtask

  task automatic test_restore();
    ras_checkpoint_t ck;
    int              t1;
    int              t2;
    apply_reset();
    do_push(12'h0A1);
    do_push(12'h0A2);
    ck.index = IW'(2);
    ck.count = CW'(2);
`ifdef RAS_REPAIR_WRITE_EN
    ck.target = 12'h0EE;
    t1 = 'h0EE;
    t2 = 'h0EE;
`else
    t1 = 'h0A2;
    t2 = 'h0FF;
`endif
    do_push(12'h0CC);
    do_push(12'h0DD);
    drive(1'b1, 12'h0F0, 1'b0, 1'b1, int'(ck.index), int'(ck.count), 12'h0EE);
    n_checks++;
    if (dut_state() !== exp_state(t1, 1'b0, 2, 2)) begin
      n_errors++;
      $display("FAIL restore_priority: got %h expected %h", dut_state(), exp_state(t1, 1'b0, 2, 2));
    end
    // Wrong-path pop then push clobbers slot 2 before the repair.
    do_pop();
    do_push(12'h0FF);
    drive(1'b0, '0, 1'b1, 1'b1, int'(ck.index), int'(ck.count), 12'h0EE);
    n_checks++;
    if (dut_state() !== exp_state(t2, 1'b0, 2, 2)) begin
      n_errors++;
      $display("FAIL restore_repair: got %h expected %h", dut_state(), exp_state(t2, 1'b0, 2, 2));
    end
    drive(1'b0, '0, 1'b0, 1'b1, 5, 0, 12'h0EE);
    n_checks++;
    if ({bus.empty, bus.index, bus.count} !== {1'b1, IW'(5), CW'(0)}) begin
      n_errors++;
      $display("FAIL restore_to_empty: got %h expected %h", {bus.empty, bus.index, bus.count},
               {1'b1, IW'(5), CW'(0)});
    end
  endtask

  task automatic test_random();
    bit pv, pp, rv;
    for (int k = 0; k < 600; k++) begin
      rv = ($urandom_range(0, 9) == 0);
      pv = ($urandom_range(0, 9) < 6);
      pp = ($urandom_range(0, 9) < 5);
      drive(pv, TW'($urandom), pp, rv, int'($urandom_range(0, D - 1)),
            int'($urandom_range(0, D)), TW'($urandom));
      n_checks++;
      if (dut_state() !== model_state()) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", k, dut_state(), model_state());
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int v = 0; v < 8; v++) do_push(TW'(12'h300 + v));
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_state() !== exp_state(0, 1'b1, 0, 0)) begin
      n_errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", dut_state(), exp_state(0, 1'b1, 0, 0));
    end
    #1;
    nrst = 1'b1;
    do_push(12'h123);
    n_checks++;
    if (dut_state() !== exp_state('h123, 1'b0, 1, 1)) begin
      n_errors++;
      $display("FAIL async_reset_first_push: got %h expected %h", dut_state(), exp_state('h123, 1'b0, 1, 1));
    end
    do_pop();
    n_checks++;
    if (dut_state() !== exp_state(0, 1'b1, 0, 0)) begin
      n_errors++;
      $display("FAIL async_reset_cleared_entry: got %h expected %h", dut_state(), exp_state(0, 1'b1, 0, 0));
    end
  endtask

  initial begin
    bus.push_valid     = 1'b0;
    bus.push_target    = '0;
    bus.pop_valid      = 1'b0;
    bus.restore_valid  = 1'b0;
    bus.restore_index  = '0;
    bus.restore_count  = '0;
    bus.restore_target = '0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_and_pop();
    test_restore();
    apply_reset();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
